// File: rtl/ram_port_arbiter_pkg.sv
// Shared types and constants for the two-master RAM port arbiter.
// Imported by ram_port_arbiter and ram_arb_perf_counter.
package ram_port_arbiter_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = 4;
    localparam int unsigned PERF_W = 32;

    typedef enum logic [1:0] {
        ARB_NONE,
        ARB_M0,
        ARB_M1
    } arb_owner_e;

    // Map a one-bit master select (0 = M0, 1 = M1) to the owner enum.
    function automatic arb_owner_e owner_of(input logic sel);
        return sel ? ARB_M1 : ARB_M0;
    endfunction

endpackage

// File: rtl/ram_arb_perf_counter.sv
// 32-bit saturating event counter used for arbiter grant/stall statistics.
// Only instantiated when RAM_ARB_PERF_EN is defined.
module ram_arb_perf_counter
    import ram_port_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              inc_i,
    output logic [PERF_W-1:0] count_o
);

    logic [PERF_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (inc_i && (count_q != {PERF_W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments; reset is synchronous and active-high.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/ram_port_arbiter.sv
// Round-robin two-master arbiter with bounded lock in front of one RAM port.
// Optional grant/stall statistics are built when RAM_ARB_PERF_EN is defined.
module ram_port_arbiter
    import ram_port_arbiter_pkg::*;
#(
    parameter  int unsigned MEM_WIDTH = 65536,
    parameter  int unsigned LOCK_MAX  = 8,
    localparam int unsigned AW        = $clog2(MEM_WIDTH)
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              m0_req_i,
    input  logic              m0_lock_i,
    input  logic [BE_W-1:0]   m0_we_i,
    input  logic [AW-1:0]     m0_addr_i,
    input  logic [DATA_W-1:0] m0_data_i,
    output logic              m0_gnt_o,
    output logic              m0_rvalid_o,
    output logic [DATA_W-1:0] m0_rdata_o,

    input  logic              m1_req_i,
    input  logic              m1_lock_i,
    input  logic [BE_W-1:0]   m1_we_i,
    input  logic [AW-1:0]     m1_addr_i,
    input  logic [DATA_W-1:0] m1_data_i,
    output logic              m1_gnt_o,
    output logic              m1_rvalid_o,
    output logic [DATA_W-1:0] m1_rdata_o,

`ifdef RAM_ARB_PERF_EN
    output logic [PERF_W-1:0] m0_grants_o,
    output logic [PERF_W-1:0] m1_grants_o,
    output logic [PERF_W-1:0] m0_stalls_o,
    output logic [PERF_W-1:0] m1_stalls_o,
`endif

    output logic              ram_en_o,
    output logic [BE_W-1:0]   ram_we_o,
    output logic [AW-1:0]     ram_addr_o,
    output logic [DATA_W-1:0] ram_data_o,
    input  logic [DATA_W-1:0] ram_data_i
);

    localparam int unsigned CW = $clog2(LOCK_MAX + 1);

    logic       last_q, last_d;
    logic [CW-1:0] lock_cnt_q, lock_cnt_d;
    arb_owner_e rd_owner_q, rd_owner_d;

    logic            both_req;
    logic            any_req;
    logic            lock_ext;
    logic            winner;
    logic            win_lock;
    logic [BE_W-1:0] win_we;

    // Winner select: a locked previous owner keeps the port until the bound is hit.
    always_comb begin
        both_req = m0_req_i & m1_req_i;
        any_req  = m0_req_i | m1_req_i;
        lock_ext = both_req
                && (last_q ? m1_lock_i : m0_lock_i)
                && (lock_cnt_q < CW'(LOCK_MAX));
        if (both_req) begin
            winner = lock_ext ? last_q : ~last_q;
        end else begin
            winner = m1_req_i;
        end
        win_lock = winner ? m1_lock_i : m0_lock_i;
        win_we   = winner ? m1_we_i : m0_we_i;
    end

    assign m0_gnt_o = any_req & ~winner;
    assign m1_gnt_o = any_req &  winner;

    assign ram_en_o   = any_req;
    assign ram_we_o   = any_req ? win_we : '0;
    assign ram_addr_o = any_req ? (winner ? m1_addr_i : m0_addr_i) : '0;
    assign ram_data_o = any_req ? (winner ? m1_data_i : m0_data_i) : '0;

    // NOTE: every combinational output gets a default first, so no latch can be inferred.
    always_comb begin
        last_d     = last_q;
        lock_cnt_d = lock_cnt_q;
        rd_owner_d = ARB_NONE;
        if (any_req) begin
            last_d = winner;
            if ((winner != last_q) || !win_lock) begin
                lock_cnt_d = '0;
            end else if (lock_ext) begin
                lock_cnt_d = lock_cnt_q + 1'b1;
            end
            if (win_we == '0) begin
                rd_owner_d = owner_of(winner);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_q     <= 1'b1;
            lock_cnt_q <= '0;
            rd_owner_q <= ARB_NONE;
        end else begin
            last_q     <= last_d;
            lock_cnt_q <= lock_cnt_d;
            rd_owner_q <= rd_owner_d;
        end
    end

    // A response still in flight when reset rises is suppressed immediately.
    assign m0_rvalid_o = (rd_owner_q == ARB_M0) && !reset;
    assign m1_rvalid_o = (rd_owner_q == ARB_M1) && !reset;
    assign m0_rdata_o  = m0_rvalid_o ? ram_data_i : '0;
    assign m1_rdata_o  = m1_rvalid_o ? ram_data_i : '0;

`ifdef RAM_ARB_PERF_EN
    ram_arb_perf_counter u_m0_grants (
        .clk     (clk),
        .reset   (reset),
        .inc_i   (m0_gnt_o),
        .count_o (m0_grants_o)
    );

    ram_arb_perf_counter u_m1_grants (
        .clk     (clk),
        .reset   (reset),
        .inc_i   (m1_gnt_o),
        .count_o (m1_grants_o)
    );

    ram_arb_perf_counter u_m0_stalls (
        .clk     (clk),
        .reset   (reset),
        .inc_i   (m0_req_i & ~m0_gnt_o),
        .count_o (m0_stalls_o)
    );

    ram_arb_perf_counter u_m1_stalls (
        .clk     (clk),
        .reset   (reset),
        .inc_i   (m1_req_i & ~m1_gnt_o),
        .count_o (m1_stalls_o)
    );
`endif

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter: directed scenarios plus random traffic
// compared every cycle against a behavioural model and a byte-array RAM.
module tb_ram_port_arbiter;
    import ram_port_arbiter_pkg::*;

    localparam int MEM_WIDTH = 65536;
    localparam int LOCK_MAX  = 8;
    localparam int AW        = $clog2(MEM_WIDTH);

    logic clk = 1'b0;
    logic reset;

    logic            m0_req_i, m0_lock_i, m1_req_i, m1_lock_i;
    logic [3:0]      m0_we_i, m1_we_i;
    logic [AW-1:0]   m0_addr_i, m1_addr_i;
    logic [31:0]     m0_data_i, m1_data_i;
    logic            m0_gnt_o, m0_rvalid_o, m1_gnt_o, m1_rvalid_o;
    logic [31:0]     m0_rdata_o, m1_rdata_o;
    logic            ram_en_o;
    logic [3:0]      ram_we_o;
    logic [AW-1:0]   ram_addr_o;
    logic [31:0]     ram_data_o, ram_data_i;
`ifdef RAM_ARB_PERF_EN
    logic [31:0]     m0_grants_o, m1_grants_o, m0_stalls_o, m1_stalls_o;
`endif

    int checks   = 0;
    int failures = 0;

    ram_port_arbiter #(.MEM_WIDTH(MEM_WIDTH), .LOCK_MAX(LOCK_MAX)) dut (
        .clk         (clk),
        .reset       (reset),
        .m0_req_i    (m0_req_i),
        .m0_lock_i   (m0_lock_i),
        .m0_we_i     (m0_we_i),
        .m0_addr_i   (m0_addr_i),
        .m0_data_i   (m0_data_i),
        .m0_gnt_o    (m0_gnt_o),
        .m0_rvalid_o (m0_rvalid_o),
        .m0_rdata_o  (m0_rdata_o),
        .m1_req_i    (m1_req_i),
        .m1_lock_i   (m1_lock_i),
        .m1_we_i     (m1_we_i),
        .m1_addr_i   (m1_addr_i),
        .m1_data_i   (m1_data_i),
        .m1_gnt_o    (m1_gnt_o),
        .m1_rvalid_o (m1_rvalid_o),
        .m1_rdata_o  (m1_rdata_o),
`ifdef RAM_ARB_PERF_EN
        .m0_grants_o (m0_grants_o),
        .m1_grants_o (m1_grants_o),
        .m0_stalls_o (m0_stalls_o),
        .m1_stalls_o (m1_stalls_o),
`endif
        .ram_en_o    (ram_en_o),
        .ram_we_o    (ram_we_o),
        .ram_addr_o  (ram_addr_o),
        .ram_data_o  (ram_data_o),
        .ram_data_i  (ram_data_i)
    );

    always #5 clk = ~clk;

    // Environment RAM: 1-cycle registered read, byte-lane writes, little-endian.
    logic [7:0]  ram_mem [MEM_WIDTH];
    logic [7:0]  ref_mem [MEM_WIDTH];
    logic [31:0] ram_rdata;
    logic        do_preload;
    assign ram_data_i = ram_rdata;

    always @(posedge clk) begin
        if (do_preload) begin
            for (int i = 0; i < MEM_WIDTH; i++) ram_mem[i] <= ref_mem[i];
            ram_rdata <= '0;
        end else if (ram_en_o) begin
            if (ram_we_o == 4'b0000) begin
                for (int b = 0; b < 4; b++)
                    ram_rdata[8*b +: 8] <= ram_mem[(int'(ram_addr_o) + b) % MEM_WIDTH];
            end else begin
                for (int b = 0; b < 4; b++)
                    if (ram_we_o[b]) ram_mem[(int'(ram_addr_o) + b) % MEM_WIDTH] <= ram_data_o[8*b +: 8];
            end
        end
    end

    // Reference model state: plain integers (-1 = nobody).
    int          e_last, e_cnt, e_pend;
    logic [31:0] e_pend_data;
    int          e_g0, e_g1, e_s0, e_s1;
    int          last_w;

    // Observed snapshot of the most recent step, for directed checks.
    logic        o_m0_gnt, o_m1_gnt, o_m0_rvalid, o_m1_rvalid;
    logic [31:0] o_m0_rdata, o_m1_rdata;
    logic [31:0] o_g0, o_g1, o_s0, o_s1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input int a);
        logic [31:0] w;
        for (int b = 0; b < 4; b++) w[8*b +: 8] = ref_mem[(a + b) % MEM_WIDTH];
        return w;
    endfunction

    // Round-robin with bounded lock, stated directly in terms of who asked.
    function automatic int exp_winner();
        bit owner_locked;
        if (m0_req_i && m1_req_i) begin
            owner_locked = (e_last == 0) ? m0_lock_i : m1_lock_i;
            if (owner_locked && e_cnt < LOCK_MAX) return e_last;
            return 1 - e_last;
        end
        if (m0_req_i) return 0;
        if (m1_req_i) return 1;
        return -1;
    endfunction

    task automatic step();
        int          w;
        logic [3:0]  xw;
        logic [31:0] xa, xd;
        bit          wl, both;
        @(negedge clk);
        w    = exp_winner();
        xw   = (w == 1) ? m1_we_i : (w == 0) ? m0_we_i : 4'b0;
        xa   = (w == 1) ? 32'(m1_addr_i) : (w == 0) ? 32'(m0_addr_i) : 32'd0;
        xd   = (w == 1) ? m1_data_i : (w == 0) ? m0_data_i : 32'd0;
        check("m0_gnt", 32'(m0_gnt_o), 32'(w == 0));
        check("m1_gnt", 32'(m1_gnt_o), 32'(w == 1));
        check("ram_en", 32'(ram_en_o), 32'(w >= 0));
        check("ram_we", 32'(ram_we_o), 32'(xw));
        check("ram_addr", 32'(ram_addr_o), xa);
        check("ram_data", ram_data_o, xd);
        check("m0_rvalid", 32'(m0_rvalid_o), 32'(e_pend == 0 && !reset));
        check("m1_rvalid", 32'(m1_rvalid_o), 32'(e_pend == 1 && !reset));
        check("m0_rdata", m0_rdata_o, (e_pend == 0 && !reset) ? e_pend_data : 32'd0);
        check("m1_rdata", m1_rdata_o, (e_pend == 1 && !reset) ? e_pend_data : 32'd0);
`ifdef RAM_ARB_PERF_EN
        check("m0_grants", m0_grants_o, 32'(e_g0));
        check("m1_grants", m1_grants_o, 32'(e_g1));
        check("m0_stalls", m0_stalls_o, 32'(e_s0));
        check("m1_stalls", m1_stalls_o, 32'(e_s1));
        o_g0 = m0_grants_o; o_g1 = m1_grants_o; o_s0 = m0_stalls_o; o_s1 = m1_stalls_o;
`endif
        o_m0_gnt = m0_gnt_o; o_m1_gnt = m1_gnt_o;
        o_m0_rvalid = m0_rvalid_o; o_m1_rvalid = m1_rvalid_o;
        o_m0_rdata = m0_rdata_o; o_m1_rdata = m1_rdata_o;

        @(posedge clk);
        // RAM side effect of this cycle's transfer (happens even under reset).
        if (w >= 0 && xw != 4'b0) begin
            for (int b = 0; b < 4; b++)
                if (xw[b]) ref_mem[(int'(xa) + b) % MEM_WIDTH] = xd[8*b +: 8];
        end
        if (reset) begin
            e_last = 1; e_cnt = 0; e_pend = -1;
            e_g0 = 0; e_g1 = 0; e_s0 = 0; e_s1 = 0;
        end else begin
            if (m0_req_i && w != 0) e_s0++;
            if (m1_req_i && w != 1) e_s1++;
            if (w == 0) e_g0++;
            if (w == 1) e_g1++;
            if (w >= 0) begin
                both = m0_req_i && m1_req_i;
                wl   = (w == 0) ? m0_lock_i : m1_lock_i;
                if (w != e_last || !wl) e_cnt = 0;
                else if (both) e_cnt++;
                e_last = w;
                if (xw == 4'b0) begin
                    e_pend = w;
                    e_pend_data = ref_word(int'(xa));
                end else begin
                    e_pend = -1;
                end
            end else begin
                e_pend = -1;
            end
        end
        last_w = w;
        #1;
    endtask

    task automatic set_m0(input bit req, input bit lock, input logic [3:0] we,
                          input int addr, input logic [31:0] data);
        m0_req_i = req; m0_lock_i = lock; m0_we_i = we;
        m0_addr_i = AW'(addr); m0_data_i = data;
    endtask

    task automatic set_m1(input bit req, input bit lock, input logic [3:0] we,
                          input int addr, input logic [31:0] data);
        m1_req_i = req; m1_lock_i = lock; m1_we_i = we;
        m1_addr_i = AW'(addr); m1_data_i = data;
    endtask

    task automatic idle();
        set_m0(0, 0, 4'b0, 0, 32'd0);
        set_m1(0, 0, 4'b0, 0, 32'd0);
    endtask

    int  m1_run;
    bit  m1_run_open;
    bit  hold0, hold1;

    initial begin
        e_last = 1; e_cnt = 0; e_pend = -1; e_pend_data = '0;
        e_g0 = 0; e_g1 = 0; e_s0 = 0; e_s1 = 0; last_w = -1;
        for (int i = 0; i < MEM_WIDTH; i++) ref_mem[i] = 8'($urandom);
        for (int b = 0; b < 4; b++) begin
            ref_mem['h0010 + b] = 8'(32'hDEADBEEF >> (8*b));
            ref_mem['h0100 + b] = 8'(32'hAABBCCDD >> (8*b));
        end
        idle();
        reset = 1'b1;
        do_preload = 1'b1;
        #1;
        step();
        do_preload = 1'b0;
        step();
        check("reset_m0_rvalid", 32'(o_m0_rvalid), 32'd0);
        reset = 1'b0;

        // Single master read.
        set_m0(1, 0, 4'b0, 'h0010, 32'd0);
        step();
        check("single_m0_gnt", 32'(o_m0_gnt), 32'd1);
        idle();
        step();
        check("single_m0_rvalid", 32'(o_m0_rvalid), 32'd1);
        check("single_m0_rdata", o_m0_rdata, 32'hDEADBEEF);
        check("single_m1_rvalid", 32'(o_m1_rvalid), 32'd0);

        // Conflict right after reset alternates starting with M0.
        reset = 1'b1; step(); reset = 1'b0;
        set_m0(1, 0, 4'b0, 'h0010, 32'd0);
        set_m1(1, 0, 4'b0, 'h0100, 32'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            check("alt_m0_gnt", 32'(o_m0_gnt), 32'(i % 2 == 0));
        end
        idle();
        step();
        check("alt_last_rvalid_m1", 32'(o_m1_rvalid), 32'd1);

        // Lock bound: M1 keeps the port for 1 + LOCK_MAX grants.
        set_m0(1, 0, 4'b0, 'h0020, 32'd0);
        step();
        set_m1(1, 1, 4'b0, 'h0030, 32'd0);
        m1_run = 0; m1_run_open = 1'b1;
        for (int i = 0; i < LOCK_MAX + 2; i++) begin
            step();
            if (o_m1_gnt && m1_run_open) m1_run++;
            else m1_run_open = 1'b0;
        end
        check("lock_m1_run", 32'(m1_run), 32'(LOCK_MAX + 1));
        check("lock_handover_m0", 32'(o_m0_gnt), 32'd1);
        idle();
        step();

        // Partial write by M1 followed by M0 read of the same word.
        set_m1(1, 0, 4'b0011, 'h0100, 32'h12345678);
        step();
        set_m1(0, 0, 4'b0, 0, 32'd0);
        set_m0(1, 0, 4'b0, 'h0100, 32'd0);
        step();
        idle();
        step();
        check("wr_rd_rdata", o_m0_rdata, 32'hAABB5678);

        // Reset while a read response is pending, and a read granted under reset.
        set_m0(1, 0, 4'b0, 'h0010, 32'd0);
        step();
        reset = 1'b1;
        set_m1(1, 0, 4'b0, 'h0100, 32'd0);
        step();
        check("rst_pending_rvalid", 32'(o_m0_rvalid), 32'd0);
        reset = 1'b0;
        step();
        check("rst_after_rvalid0", 32'(o_m0_rvalid), 32'd0);
        check("rst_after_rvalid1", 32'(o_m1_rvalid), 32'd0);
        check("rst_first_conflict_m0", 32'(o_m0_gnt), 32'd1);
        idle();
        step();

        // M0 holds lock while M1 stalls for five cycles.
        reset = 1'b1; step(); reset = 1'b0;
        set_m0(1, 1, 4'b0, 'h0040, 32'd0);
        step();
        set_m1(1, 0, 4'b0, 'h0050, 32'd0);
        for (int i = 0; i < 5; i++) step();
        idle();
        step();
`ifdef RAM_ARB_PERF_EN
        check("perf_m1_stalls", o_s1, 32'd5);
        check("perf_m0_grants", o_g0, 32'd6);
        check("perf_m1_grants", o_g1, 32'd0);
`endif
        check("perf_m1_never_granted", 32'(o_m1_rvalid), 32'd0);

        // Random traffic; a master keeps its fields until granted.
        hold0 = 1'b0; hold1 = 1'b0;
        for (int n = 0; n < 400; n++) begin
            reset = ($urandom_range(0, 39) == 0);
            if (!hold0)
                set_m0($urandom_range(0, 2) != 0, 1'($urandom), ($urandom_range(0, 1) != 0) ? 4'b0 : 4'($urandom),
                       $urandom_range(0, 'h1FF), $urandom);
            if (!hold1)
                set_m1($urandom_range(0, 2) != 0, 1'($urandom), ($urandom_range(0, 1) != 0) ? 4'b0 : 4'($urandom),
                       $urandom_range(0, 'h1FF), $urandom);
            step();
            hold0 = m0_req_i && (last_w != 0);
            hold1 = m1_req_i && (last_w != 1);
        end
        reset = 1'b0;
        idle();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
